// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, request record and controller state encoding.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } mem_req_t;
  localparam int REQ_W = $bits(mem_req_t);
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: LSQ-facing request/ack bus of the data-memory controller.
interface data_mem_ctrl_if;
  import mips_pkg::*;
  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_read_val;
  logic              busy;
  logic              req_overflow;
  logic              addr_err;
  modport master (
    output mem_req, mem_we, mem_addr, mem_data,
    input  mem_ack, mem_read_val, busy, req_overflow, addr_err
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_data,
    output mem_ack, mem_read_val, busy, req_overflow, addr_err
  );
endinterface

// File: rtl/req_fifo.sv
// req_fifo: synchronous FIFO with wrap-bit pointers and combinational head.
module req_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  assign empty = wr_q == rd_q;
  assign full = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
  assign dout = mem[rd_q[AW-1:0]];
  always_comb begin
    wr_d = push ? wr_q + ONE : wr_q;
    rd_d = pop ? rd_q + ONE : rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // a push into a full FIFO only happens alongside a pop, so overwriting the head slot is safe
  always_ff @(posedge clk)
    if (push) mem[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: buffers LSQ requests in order and services them against a
// word RAM with programmable latency, one ack pulse per request.
module data_mem_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  mem_req_t cur_q, cur_d, head, in_req;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic err_q, err_d, ovf_q, ovf_d, full, empty, push, pop, access, bad;
  logic [AW-1:0] idx;
  logic [WORD_W-1:0] ram [DEPTH];
  assign in_req = '{we: bus.mem_we, addr: bus.mem_addr, data: bus.mem_data};
  assign pop = !empty && (state_q == ST_IDLE || state_q == ST_RESP);
  assign push = bus.mem_req && (!full || pop);
  assign access = state_q == ST_WAIT && cnt_q == '0;
  assign bad = cur_q.addr[1:0] != 2'b0 || {2'b0, cur_q.addr[WORD_W-1:2]} >= 32'(DEPTH);
  assign idx = cur_q.addr[AW+1:2];
  req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst_n),
    .push(push),
    .pop(pop),
    .din(in_req),
    .full(full),
    .empty(empty),
    .dout(head)
  );
  always_comb begin
    state_d = pop ? ST_WAIT : access ? ST_RESP : (state_q == ST_RESP ? ST_IDLE : state_q);
    cnt_d = pop ? 4'(LATENCY - 1) : ((access || state_q != ST_WAIT) ? cnt_q : cnt_q - 4'd1);
    cur_d = pop ? head : cur_q;
    rdata_d = !access ? rdata_q : ((cur_q.we || bad) ? '0 : ram[idx]);
    err_d = access && bad;
    ovf_d = ovf_q || (bus.mem_req && !push);
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      cur_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end
  // a reset on the access edge abandons the store
  always_ff @(posedge clk)
    if (!rst_n && access && cur_q.we && !bad) ram[idx] <= cur_q.data;
  assign bus.mem_ack = state_q == ST_RESP;
  assign bus.busy = !empty || state_q != ST_IDLE;
  assign bus.mem_read_val = rdata_q;
  assign bus.addr_err = err_q;
  assign bus.req_overflow = ovf_q;
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller directly downstream of the load/store queue. It accepts the LSQ's single-cycle memory request pulses, buffers them in a small in-order request FIFO, and services them one at a time against an internal word-addressed RAM with a programmable access latency. Each access produces a one-cycle `mem_ack` pulse, with read data for loads, which the LSQ uses to retire the entry.

## Interface
- `DEPTH`, 1024 — RAM size in 32-bit words; power of two.
- `LATENCY`, 2 — cycles from access start to ack; legal range 1..15.
- `FIFO_DEPTH`, 4 — request FIFO entries; power of two, ≥2.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset; synchronous, active-high despite the name (asserted = 1).
- `mem_req` in 1 — one-cycle request pulse from the LSQ.
- `mem_we` in 1 — 1 = store, 0 = load; sampled with `mem_req`.
- `mem_addr` in 32 — byte address; sampled with `mem_req`.
- `mem_data` in 32 — store data; sampled with `mem_req`.
- `mem_ack` out 1 — one-cycle completion pulse.
- `mem_read_val` out 32 — load data, valid with `mem_ack`; 0 for stores.
- `busy` out 1 — FIFO non-empty or access in flight.
- `req_overflow` out 1 — sticky; set when a request arrives with the FIFO full.
- `addr_err` out 1 — one-cycle pulse, coincident with `mem_ack`, for a misaligned or out-of-range access.

## Operation
- **Reset.** All outputs are 0. FIFO is empty, FSM is IDLE, latency counter is 0. RAM contents are not cleared.
- **Enqueue.** `mem_req`=1 with the FIFO not full pushes {we, addr, data}.
  - With the FIFO full, the request is dropped and `req_overflow` is set. It stays set until reset.
  - `mem_req` has no backpressure; the LSQ is never stalled.
- **FSM, IDLE.** If the FIFO is non-empty, pop the head into the working registers, load the counter with `LATENCY-1`, and go to WAIT.
- **FSM, WAIT.** Decrement the counter. When it reaches 0, perform the RAM access and go to RESP.
  - Word index = `addr[log2(DEPTH)+1:2]`.
  - Store: write `data` to the word.
  - Load: read the word into `mem_read_val`.
- **FSM, RESP.** Assert `mem_ack` for exactly this cycle.
  - If the FIFO is non-empty, pop the next request and go straight to WAIT (back-to-back service).
  - Otherwise go to IDLE.
- **Errors.** An address is in error if `addr[1:0]`≠0 or `addr[31:2]` ≥ `DEPTH`.
  - Errored store: the write is suppressed.
  - Errored load: returns 0.
  - In both cases `addr_err` pulses with the ack.
- **Response data.** `mem_read_val` holds its value after the ack. Store acks drive it to 0.
- **Ordering.** Requests complete strictly in arrival order, so a load after a store to the same word returns the stored data.
- **Simultaneous push and pop.** Both are allowed in the same cycle. When the FIFO is full, a same-cycle pop frees a slot, so the push succeeds and no overflow is flagged.
- **FIFO pointers.** `log2(FIFO_DEPTH)+1` bits wide; they wrap naturally. Full = MSBs differ and the rest are equal.
- **Reset mid-operation.** Any in-flight access is abandoned with no ack. A write is not performed unless it already completed in an earlier cycle.

## Timing
- Request sampled at edge T into an empty, idle controller:
  - T+1: request popped, state is WAIT.
  - `mem_ack` high in the cycle starting at edge T+1+`LATENCY`.
  - Minimum request-to-ack is `LATENCY`+1 cycles.
- Back-to-back service: one ack every `LATENCY`+1 cycles.
- `mem_read_val` and `addr_err` are registered and update on the same edge that raises `mem_ack`.
- `busy` is combinational from FIFO-empty and FSM state. It rises the cycle after the first accepted `mem_req`.

## Structure
- Shared package `mips_pkg` holds:
  - FSM state encoding {IDLE, WAIT, RESP}.
  - `WORD_W`=32.
  - The request struct/field widths {we, addr[31:0], data[31:0]}.
- One sub-module, `req_fifo`: synchronous FIFO parameterised by width and depth, with push, pop, full, empty and head data.
- RAM is an inferred register array inside `data_mem_ctrl`.

## Test plan
- **Store then load, LATENCY=2.** Store 0xDEADBEEF to 0x40, then load 0x40.
  - Store ack: `mem_read_val`=0.
  - Load ack: `mem_read_val`=0xDEADBEEF.
  - Each ack arrives 3 cycles after its service starts; `addr_err`=0.
- **Burst of 4 requests, one per cycle, FIFO_DEPTH=4.** 4 acks in order, spaced 3 cycles apart; `req_overflow` stays 0.
- **6 requests, one per cycle, FIFO_DEPTH=4, LATENCY=15.**
  - The 6th request is dropped and `req_overflow`=1.
  - Exactly 5 acks occur.
- **Misaligned and out-of-range, DEPTH=1024.**
  - Load 0x41: ack with `addr_err`=1, data 0.
  - Store 0x1000: `addr_err`=1.
  - A later load 0x0 returns its prior value, unchanged.
- **Reset mid-access.** Assert `rst_n`=1 during WAIT of a store to 0x80.
  - No ack occurs; all outputs are 0 the next cycle.
  - A load of 0x80 returns the old value.
- **Full FIFO with simultaneous pop.** Push into a full FIFO in the same cycle as a RESP pop: the request is accepted, `req_overflow` stays 0, and it is acked in order.
